// File: rtl/handshake_mux_buf.sv
// Select-steered N:1 handshake multiplexer feeding a 2-entry output FIFO.
// Out-of-range selects are dropped and tallied in sticky/saturating error state.
module handshake_mux_buf #(
    parameter int NUM_INPUTS = 2,
    parameter int WIDTH      = 32,
    localparam int SEL_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sel_valid,
    output logic                        sel_ready,
    input  logic [SEL_WIDTH-1:0]        sel_data,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    output logic [NUM_INPUTS-1:0]       in_ready,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    input  logic                        err_clear,
    output logic                        err_sticky,
    output logic [7:0]                  err_count,
    output logic [1:0]                  occupancy
);

    localparam logic [SEL_WIDTH:0] NUM_IN_W = (SEL_WIDTH + 1)'(NUM_INPUTS);

    logic [WIDTH-1:0] mem [2];
    logic             head_ptr;
    logic             tail_ptr;
    logic [1:0]       count;
    logic             err_sticky_q;
    logic [7:0]       err_count_q;

    logic             space;
    logic             in_range;
    logic             sel_in_valid;
    logic             fire;
    logic             bad_sel;
    logic             deq;
    logic [WIDTH-1:0] sel_word;

    // Explicit compare loop keeps out-of-range selects from indexing past the input vectors.
    always_comb begin
        sel_in_valid = 1'b0;
        sel_word     = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel_data == SEL_WIDTH'(i)) begin
                sel_in_valid = in_valid[i];
                sel_word     = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_range  = {1'b0, sel_data} < NUM_IN_W;
    assign space     = count < 2'd2;
    assign fire      = !rst && sel_valid && in_range && sel_in_valid && space;
    assign bad_sel   = !rst && sel_valid && !in_range;
    assign sel_ready = fire || bad_sel;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_ready[i] = fire && (sel_data == SEL_WIDTH'(i));
        end
    end

    assign out_valid  = !rst && (count != 2'd0);
    assign out_data   = mem[head_ptr];
    assign deq        = out_valid && out_ready;
    assign occupancy  = rst ? 2'd0 : count;
    assign err_sticky = !rst && err_sticky_q;
    assign err_count  = rst ? 8'd0 : err_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (fire) tail_ptr <= ~tail_ptr;
            if (deq)  head_ptr <= ~head_ptr;
            unique case ({fire, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; the pointers and count alone decide what is visible.
    always_ff @(posedge clk) begin
        if (fire) mem[tail_ptr] <= sel_word;
    end

    always_ff @(posedge clk) begin
        if (rst || err_clear) begin
            err_sticky_q <= 1'b0;
            err_count_q  <= 8'd0;
        end else if (bad_sel) begin
            err_sticky_q <= 1'b1;
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_handshake_mux_buf.sv
// Self-checking bench: directed vector table, corner sequences and random traffic
// compared against a queue-based reference model; a second 3-input instance covers bad selects.
module tb_handshake_mux_buf;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel_valid;
    logic         sel_ready;
    logic [1:0]   sel_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         err_clear;
    logic         err_sticky;
    logic [7:0]   err_count;
    logic [1:0]   occupancy;

    logic         rst3;
    logic         sel_valid3;
    logic         sel_ready3;
    logic [1:0]   sel_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [23:0]  in_data3;
    logic         out_valid3;
    logic         out_ready3;
    logic [7:0]   out_data3;
    logic         err_clear3;
    logic         err_sticky3;
    logic [7:0]   err_count3;
    logic [1:0]   occupancy3;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] modelQ[$];
    int          occ3 = 0;
    int          errCnt3 = 0;
    logic        errSt3 = 1'b0;

    logic        lastSr;
    logic [3:0]  lastIr;
    logic [1:0]  lastOcc;
    logic        lastOutValid;

    typedef struct {
        logic       r;
        logic       sv;
        logic [1:0] sd;
        logic [3:0] iv;
        logic       ordy;
        logic       expSr;
        logic [3:0] expIr;
        logic [1:0] expOcc;
    } vec_t;

    vec_t         vecs[13];
    logic [127:0] tableData;
    int           streamValid;

    handshake_mux_buf #(.NUM_INPUTS(4), .WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_data(sel_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_clear(err_clear), .err_sticky(err_sticky), .err_count(err_count),
        .occupancy(occupancy)
    );

    handshake_mux_buf #(.NUM_INPUTS(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst3),
        .sel_valid(sel_valid3), .sel_ready(sel_ready3), .sel_data(sel_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
        .err_clear(err_clear3), .err_sticky(err_sticky3), .err_count(err_count3),
        .occupancy(occupancy3)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle on the 4-input instance: drive, check against the queue model, clock, update model.
    task automatic applyStimulus(input logic r, input logic sv, input logic [1:0] sd,
                                 input logic [3:0] iv, input logic [127:0] id, input logic ordy);
        logic        fireExp;
        logic [3:0]  irExp;
        logic [31:0] word;
        rst = r; sel_valid = sv; sel_data = sd; in_valid = iv; in_data = id;
        out_ready = ordy; err_clear = 1'b0;
        #1;
        fireExp = !r && sv && iv[sd] && (modelQ.size() < 2);
        irExp   = fireExp ? (4'b0001 << sd) : 4'b0000;
        word    = id[sd*32 +: 32];
        checkOutput("sel_ready", 64'(sel_ready), 64'(fireExp));
        checkOutput("in_ready", 64'(in_ready), 64'(irExp));
        checkOutput("out_valid", 64'(out_valid), 64'(!r && modelQ.size() != 0));
        checkOutput("occupancy", 64'(occupancy), r ? 64'd0 : 64'(modelQ.size()));
        checkOutput("err_count4", 64'({err_sticky, err_count}), 64'd0);
        if (!r && modelQ.size() != 0) checkOutput("out_data", 64'(out_data), 64'(modelQ[0]));
        lastSr = sel_ready; lastIr = in_ready; lastOcc = occupancy; lastOutValid = out_valid;
        @(posedge clk);
        if (r) modelQ.delete();
        else begin
            if (ordy && modelQ.size() != 0) void'(modelQ.pop_front());
            if (fireExp) modelQ.push_back(word);
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus3(input logic r, input logic sv, input logic [1:0] sd,
                                  input logic [2:0] iv, input logic clr, input logic ordy);
        logic       inr;
        logic       bad;
        logic       fireExp;
        logic [2:0] irExp;
        rst3 = r; sel_valid3 = sv; sel_data3 = sd; in_valid3 = iv;
        err_clear3 = clr; out_ready3 = ordy; in_data3 = 24'($urandom);
        #1;
        inr     = (sd < 2'd3);
        bad     = !r && sv && !inr;
        fireExp = !r && sv && inr && (((iv >> sd) & 3'b001) != 3'b000) && (occ3 < 2);
        irExp   = fireExp ? 3'(3'b001 << sd) : 3'b000;
        checkOutput("sel_ready3", 64'(sel_ready3), 64'(fireExp || bad));
        checkOutput("in_ready3", 64'(in_ready3), 64'(irExp));
        checkOutput("err_sticky3", 64'(err_sticky3), 64'(errSt3));
        checkOutput("err_count3", 64'(err_count3), 64'(errCnt3));
        checkOutput("occupancy3", 64'(occupancy3), 64'(occ3));
        @(posedge clk);
        if (r) begin
            occ3 = 0; errCnt3 = 0; errSt3 = 1'b0;
        end else begin
            if (ordy && occ3 > 0) occ3--;
            if (fireExp) occ3++;
            if (clr) begin
                errCnt3 = 0; errSt3 = 1'b0;
            end else if (bad) begin
                errSt3 = 1'b1;
                if (errCnt3 < 255) errCnt3++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; sel_valid = 1'b0; sel_data = '0; in_valid = '0; in_data = '0;
        out_ready = 1'b0; err_clear = 1'b0;
        rst3 = 1'b1; sel_valid3 = 1'b0; sel_data3 = '0; in_valid3 = '0; in_data3 = '0;
        out_ready3 = 1'b0; err_clear3 = 1'b0;
        tableData = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

        vecs[0]  = '{1'b0, 1'b1, 2'd2, 4'b1111, 1'b1, 1'b1, 4'b0100, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 4'b1111, 1'b0, 1'b1, 4'b0001, 2'd0};
        vecs[3]  = '{1'b0, 1'b1, 2'd1, 4'b1111, 1'b0, 1'b1, 4'b0010, 2'd1};
        vecs[4]  = '{1'b0, 1'b1, 2'd3, 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd2};
        vecs[5]  = '{1'b0, 1'b1, 2'd3, 4'b1111, 1'b1, 1'b0, 4'b0000, 2'd2};
        vecs[6]  = '{1'b0, 1'b1, 2'd3, 4'b1111, 1'b1, 1'b1, 4'b1000, 2'd1};
        vecs[7]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 4'b1101, 1'b1, 1'b0, 4'b0000, 2'd0};
        vecs[9]  = '{1'b0, 1'b1, 2'd1, 4'b1101, 1'b1, 1'b0, 4'b0000, 2'd0};
        vecs[10] = '{1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 1'b1, 4'b0010, 2'd0};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd1};
        vecs[12] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0};

        @(negedge clk);
        $display("[TB] reset and directed vectors");
        applyStimulus(1'b1, 1'b1, 2'd2, 4'hF, tableData, 1'b1);
        applyStimulus(1'b1, 1'b1, 2'd2, 4'hF, tableData, 1'b1);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].r, vecs[i].sv, vecs[i].sd, vecs[i].iv, tableData, vecs[i].ordy);
            checkOutput("vec_sel_ready", 64'(lastSr), 64'(vecs[i].expSr));
            checkOutput("vec_in_ready", 64'(lastIr), 64'(vecs[i].expIr));
            checkOutput("vec_occupancy", 64'(lastOcc), 64'(vecs[i].expOcc));
        end

        $display("[TB] reset with a full buffer");
        applyStimulus(1'b0, 1'b1, 2'd0, 4'hF, {4{$urandom}}, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd1, 4'hF, {4{$urandom}}, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd2, 4'hF, {4{$urandom}}, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, tableData, 1'b1);
        checkOutput("post_reset_occ", 64'(lastOcc), 64'd0);
        checkOutput("post_reset_valid", 64'(lastOutValid), 64'd0);
        applyStimulus(1'b0, 1'b1, 2'd3, 4'hF, tableData, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'h0, tableData, 1'b1);

        $display("[TB] streaming throughput");
        streamValid = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, 2'(i % 2), 4'hF,
                          {$urandom, $urandom, $urandom, $urandom}, 1'b1);
            if (i > 0 && lastOutValid) streamValid++;
        end
        checkOutput("stream_no_bubbles", 64'(streamValid), 64'd19);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
                          2'($urandom), 4'($urandom),
                          {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
        end

        $display("[TB] bad-select handling on 3-input instance");
        applyStimulus3(1'b1, 1'b1, 2'd3, 3'b111, 1'b0, 1'b0);
        applyStimulus3(1'b0, 1'b1, 2'd2, 3'b100, 1'b0, 1'b0);
        applyStimulus3(1'b0, 1'b1, 2'd0, 3'b111, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) applyStimulus3(1'b0, 1'b1, 2'd3, 3'b111, 1'b0, 1'b0);
        checkOutput("err_count_saturated", 64'(err_count3), 64'd255);
        checkOutput("err_sticky_set", 64'(err_sticky3), 64'd1);
        checkOutput("bad_no_write", 64'(occupancy3), 64'd2);
        applyStimulus3(1'b0, 1'b1, 2'd3, 3'b111, 1'b1, 1'b1);
        checkOutput("err_clear_count", 64'(err_count3), 64'd0);
        checkOutput("err_clear_sticky", 64'(err_sticky3), 64'd0);
        applyStimulus3(1'b0, 1'b1, 2'd3, 3'b000, 1'b0, 1'b1);
        applyStimulus3(1'b0, 1'b1, 2'd1, 3'b010, 1'b0, 1'b1);
        applyStimulus3(1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/handshake_mux_buf.md
HANDSHAKE_MUX_BUF -- requirements
Module: handshake_mux_buf

Interface
REQ-001 The block SHALL have the parameter NUM_INPUTS, default 2, giving the number of data inputs; legal range is 1 to 64.
REQ-002 The block SHALL have the parameter WIDTH, default 32, giving the data width in bits; it SHALL be at least 1.
REQ-003 The block SHALL have the derived localparam SEL_WIDTH, equal to $clog2(NUM_INPUTS) when NUM_INPUTS>1, else 1.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: reset; it is synchronous and active-high.
REQ-006 The block SHALL have the ports sel_valid (input, 1), sel_ready (output, 1) and sel_data (input, SEL_WIDTH): the select channel.
REQ-007 The block SHALL have the ports in_valid (input, NUM_INPUTS), in_ready (output, NUM_INPUTS) and in_data (input, NUM_INPUTS x WIDTH, packed): the data channels.
REQ-008 The block SHALL have the ports out_valid (output, 1), out_ready (input, 1) and out_data (output, WIDTH): the output channel.
REQ-009 The block SHALL have the port err_clear, input, 1 bit: clears err_sticky and err_count.
REQ-010 The block SHALL have the port err_sticky, output, 1 bit: an out-of-range select has been seen.
REQ-011 The block SHALL have the port err_count, output, 8 bits: saturating count of out-of-range selects.
REQ-012 The block SHALL have the port occupancy, output, 2 bits: number of entries in the output buffer (0-2).

Function
REQ-013 The output buffer SHALL be a 2-entry FIFO (head/tail pointers plus count); out_valid = (count!=0); out_data = head entry.
REQ-014 space = (count<2), computed from registered state only; no input ready SHALL depend combinationally on out_ready.
REQ-015 in_range = (sel_data < NUM_INPUTS).
REQ-016 Fire condition: fire = sel_valid & in_range & in_valid[sel_data] & space.
REQ-017 On fire, sel_ready=1 and in_ready[sel_data]=1; all other in_ready SHALL be 0.
REQ-018 On fire, the FIFO SHALL capture in_data[sel_data] at the clock edge.
REQ-019 Non-selected inputs SHALL never be consumed (partial consume).
REQ-020 Latency SHALL be 1 cycle: data accepted at edge N is visible on out_data after edge N.
REQ-021 Throughput SHALL be one token per cycle when out_ready is held at 1.
REQ-022 Bad-select drop: when sel_valid & !in_range, sel_ready=1 regardless of space, all in_ready=0, and no FIFO write occurs.
REQ-023 On a bad-select drop, err_sticky SHALL be set at the edge and err_count SHALL increment, saturating at 255.
REQ-024 Dequeue SHALL occur when out_valid & out_ready.
REQ-025 At count=1, a simultaneous enqueue and dequeue SHALL leave count at 1 and the data ordering preserved.
REQ-026 At count=2, no enqueue SHALL occur; a dequeue alone SHALL take count to 1.
REQ-027 At count=0, only an enqueue can occur; out_valid SHALL be 0 and out_data is don't-care.
REQ-028 Pointers SHALL wrap modulo 2; FIFO order SHALL equal fire order.
REQ-029 err_clear SHALL have priority over a same-cycle increment: err_sticky=0 and err_count=0 after that edge.
REQ-030 When NUM_INPUTS=1, every sel_data value SHALL be in range only if it equals 0; sel_data=1 SHALL be a bad select.
REQ-031 All handshake outputs SHALL be combinational functions of inputs and registered state, with no latches.

Reset
REQ-032 While rst=1 at an edge, count, pointers, err_sticky and err_count SHALL all be cleared to 0.
REQ-033 During and after reset, out_valid=0, occupancy=0, err_sticky=0 and err_count=0.
REQ-034 While rst=1, sel_ready=0 and all in_ready=0, so no token is consumed during reset.
REQ-035 Reset mid-operation SHALL discard buffered tokens; FIFO data storage need not be reset.

Verification
REQ-036 NUM_INPUTS=4, WIDTH=32, out_ready=1, sel=2, in_valid=4'b1111, in_data[2]=0xA5A5_0002 -> in_ready=4'b0100 and sel_ready=1 that cycle; next cycle out_valid=1, out_data=0xA5A5_0002.
REQ-037 out_ready=0, three selects back-to-back to inputs 0, 1, 3 -> first two accepted with occupancy 2; third stalls with sel_ready=0; releasing out_ready -> outputs in order 0, 1, 3.
REQ-038 NUM_INPUTS=3, sel_data=3 with sel_valid for 300 cycles -> sel_ready=1 each cycle, no in_ready, err_sticky=1, err_count=255; then err_clear -> both 0.
REQ-039 Continuous stream with out_ready=1, alternating selects -> one token per cycle, no bubbles after the first.
REQ-040 Assert rst with occupancy=2 -> next cycle out_valid=0 and occupancy=0; earlier tokens never appear.
REQ-041 sel_valid=1, selected in_valid=0, other inputs valid -> no consumption on any channel until the selected input becomes valid.
